// File: rtl/magic_seq_pkg.sv
// Shared types and widths for the MAGIC NOR sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package magic_seq_pkg;

    localparam int NUM_IN     = 9;
    localparam int NUM_CELLS  = 288;
    localparam int CELL_AW    = 9;
    localparam int PROG_DEPTH = 512;
    localparam int PROG_AW    = 9;
    localparam int INSTR_W    = 2 + 3 * CELL_AW;

    typedef enum logic [1:0] {
        OP_NOR2 = 2'd0,
        OP_INV1 = 2'd1,
        OP_OUT  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // Op word layout {op, a, b, d}, d in the LSBs.
    typedef struct packed {
        op_e                op;
        logic [CELL_AW-1:0] a;
        logic [CELL_AW-1:0] b;
        logic [CELL_AW-1:0] d;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Write-port mode of the cell array: INIT sets the cell, EVAL conditionally resets it.
    typedef enum logic {
        WR_INIT = 1'b0,
        WR_EVAL = 1'b1
    } wr_mode_e;

endpackage

// File: rtl/magic_cell_array.sv
// Behavioural model of one MAGIC crossbar row: two async reads, one MAGIC write, input load.
// Latency: reads combinational, writes/loads take effect on the next rising edge.
// Backpressure: none; the sequencer never loads and writes in the same cycle.
module magic_cell_array
    import magic_seq_pkg::*;
(
    input  logic               clk,
    input  logic [CELL_AW-1:0] rd_a_addr_i,
    input  logic [CELL_AW-1:0] rd_b_addr_i,
    output logic               rd_a_o,
    output logic               rd_b_o,
    input  logic               wr_en_i,
    input  wr_mode_e           wr_mode_i,
    input  logic [CELL_AW-1:0] wr_addr_i,
    input  logic               use_b_i,
    input  logic               load_en_i,
    input  logic [NUM_IN-1:0]  load_vec_i
);

    // Cell state is deliberately not reset: a real crossbar keeps its contents.
    logic cells_q [NUM_CELLS];

    // Out-of-range reads return 0; the sequencer flags such ops as illegal anyway.
    always_comb begin
        rd_a_o = 1'b0;
        rd_b_o = 1'b0;
        if (rd_a_addr_i < CELL_AW'(NUM_CELLS)) rd_a_o = cells_q[rd_a_addr_i];
        if (rd_b_addr_i < CELL_AW'(NUM_CELLS)) rd_b_o = cells_q[rd_b_addr_i];
    end

    // Parallel input load plus MAGIC write (set to 1, or AND with the NOR of the operands).
    always_ff @(posedge clk) begin
        if (load_en_i) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cells_q[i] <= load_vec_i[i];
            end
        end
        if (wr_en_i && (wr_addr_i < CELL_AW'(NUM_CELLS))) begin
            if (wr_mode_i == WR_INIT) begin
                cells_q[wr_addr_i] <= 1'b1;
            end else begin
                cells_q[wr_addr_i] <= cells_q[wr_addr_i] & ~(rd_a_o | (use_b_i & rd_b_o));
            end
        end
    end

endmodule

// File: rtl/magic_nor_sequencer.sv
// Runs a loaded NOR/INV op program on the cell array, two cycles per gate, one job at a time.
// Latency: out_valid rises 2G+1 cycles after the accept edge for G gates before OUT (1 on an illegal op).
// Backpressure: result held in DONE until out_ready; in_ready low while busy or while prog_we is high.
module magic_nor_sequencer
    import magic_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  in_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic               out_err,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [PROG_AW-1:0] pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic               out_bit_q, out_bit_d;
    logic               out_err_q, out_err_d;

    logic [INSTR_W-1:0] prog_mem_q [PROG_DEPTH];
    instr_t             instr;
    logic               is_gate, is_nor, illegal;
    logic               rd_a, rd_b;
    logic               load_en, wr_en;
    wr_mode_e           wr_mode;

    // Program memory has no reset so contents survive rst_n; writes only land while idle.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && prog_we) begin
            prog_mem_q[prog_addr] <= prog_wdata;
        end
    end

    assign instr   = instr_t'(prog_mem_q[pc_q]);
    assign is_nor  = (instr.op == OP_NOR2);
    assign is_gate = is_nor || (instr.op == OP_INV1);

    // An op is illegal if it is reserved, touches a missing cell, aliases its destination
    // with an operand, or is a gate in the last slot where pc would wrap.
    always_comb begin
        illegal = (instr.op == OP_RSVD)
               || (instr.a >= CELL_AW'(NUM_CELLS))
               || (is_gate && (instr.d >= CELL_AW'(NUM_CELLS)))
               || (is_gate && (instr.d == instr.a))
               || (is_nor  && (instr.b >= CELL_AW'(NUM_CELLS)))
               || (is_nor  && (instr.d == instr.b))
               || (is_gate && (pc_q == PROG_AW'(PROG_DEPTH - 1)));
    end

    magic_cell_array u_cells (
        .clk         (clk),
        .rd_a_addr_i (instr.a),
        .rd_b_addr_i (instr.b),
        .rd_a_o      (rd_a),
        .rd_b_o      (rd_b),
        .wr_en_i     (wr_en),
        .wr_mode_i   (wr_mode),
        .wr_addr_i   (instr.d),
        .use_b_i     (is_nor),
        .load_en_i   (load_en),
        .load_vec_i  (in_vec)
    );

    // Next-state, cell-array control and handshake decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_err_d   = out_err_q;
        in_ready    = 1'b0;
        load_en     = 1'b0;
        wr_en       = 1'b0;
        wr_mode     = WR_INIT;
        case (state_q)
            ST_IDLE: begin
                in_ready = !prog_we;
                if (in_valid && !prog_we) begin
                    load_en = 1'b1;
                    pc_d    = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (illegal) begin
                    out_bit_d   = 1'b0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (instr.op == OP_OUT) begin
                    out_bit_d   = rd_a;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    wr_en   = 1'b1;
                    wr_mode = WR_INIT;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                wr_en   = 1'b1;
                wr_mode = WR_EVAL;
                pc_d    = pc_q + 1'b1;
                state_d = ST_INIT;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state; an asynchronous reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Self-checking bench: 9symml netlist, random op programs against an op interpreter, directed corners.
// Latency: measured per job in edges after the accept edge.
// Backpressure: exercises out_ready stall in DONE and prog_we vs in_valid collision.
module tb_magic_nor_sequencer;
    import magic_seq_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               prog_we;
    logic [PROG_AW-1:0] prog_addr;
    logic [INSTR_W-1:0] prog_wdata;
    logic               in_valid;
    logic               in_ready;
    logic [NUM_IN-1:0]  in_vec;
    logic               out_valid;
    logic               out_ready;
    logic               out_bit;
    logic               out_err;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Program image as seen by the reference interpreter.
    int m_op [PROG_DEPTH];
    int m_a  [PROG_DEPTH];
    int m_b  [PROG_DEPTH];
    int m_d  [PROG_DEPTH];
    int np;
    int nc;

    magic_nor_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input int op, input int a, input int b, input int d);
        logic [1:0]         o2;
        logic [CELL_AW-1:0] a9, b9, d9;
        o2 = op[1:0]; a9 = a[CELL_AW-1:0]; b9 = b[CELL_AW-1:0]; d9 = d[CELL_AW-1:0];
        return {o2, a9, b9, d9};
    endfunction

    // Interprets the program one op at a time: gates cost 2 cycles, OUT or an illegal op cost 1.
    function automatic void model(input logic [NUM_IN-1:0] vec, output int ebit,
                                  output int eerr, output int elat);
        bit c [NUM_CELLS];
        int op, a, b, d;
        bit bad;
        for (int i = 0; i < NUM_CELLS; i++) c[i] = 1'b0;
        for (int i = 0; i < NUM_IN; i++) c[i] = vec[i];
        elat = 0; ebit = 0; eerr = 1;
        for (int pc = 0; pc < PROG_DEPTH; pc++) begin
            op = m_op[pc]; a = m_a[pc]; b = m_b[pc]; d = m_d[pc];
            bad = (op == 3) || (a >= NUM_CELLS)
               || ((op <= 1) && ((d >= NUM_CELLS) || (d == a) || (pc == PROG_DEPTH - 1)))
               || ((op == 0) && ((b >= NUM_CELLS) || (d == b)));
            elat += (bad || op == 2) ? 1 : 2;
            if (bad) begin
                ebit = 0; eerr = 1; return;
            end
            if (op == 2) begin
                ebit = int'(c[a]); eerr = 0; return;
            end
            c[d] = (op == 0) ? !(c[a] || c[b]) : !c[a];
        end
    endfunction

    // Netlist construction helpers: each gate gets a fresh destination cell.
    function automatic int g(input int op, input int a, input int b);
        int d;
        d = nc; nc++;
        m_op[np] = op; m_a[np] = a; m_b[np] = b; m_d[np] = d; np++;
        return d;
    endfunction
    function automatic int nor2(input int a, input int b); return g(0, a, b); endfunction
    function automatic int inv1(input int a);              return g(1, a, 0); endfunction
    function automatic int or2(input int a, input int b);  return inv1(nor2(a, b)); endfunction

    // 9symml via a running thermometer code c[k] = "at least k ones so far", saturating at 7;
    // result is (>=3) & ~(>=7), padded with harmless INVs to 270 gates, OUT at pc 270.
    function automatic void build_9symml();
        int c [1:8];
        int n [1:8];
        int nx, top, f;
        np = 0; nc = NUM_IN;
        c[1] = 0;
        for (int i = 1; i < NUM_IN; i++) begin
            nx  = inv1(i);
            top = (i + 1 < 7) ? i + 1 : 7;
            for (int k = 1; k <= top; k++) begin
                if (k == 1)          n[k] = or2(c[1], i);
                else if (k == i + 1) n[k] = nor2(inv1(c[k-1]), nx);
                else                 n[k] = or2(c[k], nor2(inv1(c[k-1]), nx));
            end
            for (int k = 1; k <= top; k++) c[k] = n[k];
        end
        f = nor2(inv1(c[3]), c[7]);
        while (np < 270) begin
            m_op[np] = 1; m_a[np] = 0; m_b[np] = 0; m_d[np] = NUM_CELLS - 1; np++;
        end
        m_op[270] = 2; m_a[270] = f; m_b[270] = 0; m_d[270] = 0;
    endfunction

    // Random program: operands only from inputs or cells already written, occasional illegal op.
    function automatic void gen_rand(input int len);
        int defq [$];
        int op, a, b, d;
        for (int i = 0; i < NUM_IN; i++) defq.push_back(i);
        for (int p = 0; p < len; p++) begin
            op = int'($urandom_range(0, 1));
            a  = defq[$urandom_range(0, defq.size() - 1)];
            b  = (op == 0) ? defq[$urandom_range(0, defq.size() - 1)] : int'($urandom_range(0, 511));
            d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NUM_IN - 1))
                                             : int'($urandom_range(NUM_IN, NUM_CELLS - 1));
            case ($urandom_range(0, 15))
                0: op = 3;
                1: a  = int'($urandom_range(NUM_CELLS, 511));
                2: d  = a;
                3: d  = int'($urandom_range(NUM_CELLS, 511));
                default: ;
            endcase
            m_op[p] = op; m_a[p] = a; m_b[p] = b; m_d[p] = d;
            defq.push_back(d);
        end
        m_op[len] = 2; m_a[len] = defq[$urandom_range(0, defq.size() - 1)]; m_b[len] = 0; m_d[len] = 0;
    endfunction

    task automatic write_prog(input int addr, input logic [INSTR_W-1:0] w);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = addr[PROG_AW-1:0]; prog_wdata = w;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic load_prog(input int n);
        for (int p = 0; p < n; p++) write_prog(p, mk(m_op[p], m_a[p], m_b[p], m_d[p]));
    endtask

    // Presents a job and returns #1 after its accept edge.
    task automatic accept(input string tag, input logic [NUM_IN-1:0] vec);
        int guard = 0;
        @(negedge clk);
        in_vec = vec; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk); guard++;
        end
        chk({tag, "_accept"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One complete job: accept, time the result, compare with the interpreter,
    // optionally stall in DONE for 'hold' cycles, then consume the result.
    task automatic run_job(input string tag, input logic [NUM_IN-1:0] vec, input int hold,
                           output int gbit, output int glat);
        int ebit, eerr, elat, lat;
        model(vec, ebit, eerr, elat);
        accept(tag, vec);
        lat = 0;
        while (!out_valid && lat < 2000) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_bit"}, int'(out_bit), ebit);
        chk({tag, "_err"}, int'(out_err), eerr);
        gbit = int'(out_bit); glat = lat;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            prog_we = h[0]; prog_addr = '0; prog_wdata = mk(2, 3, 0, 0);
            #1;
            chk({tag, "_hold_vld"}, int'(out_valid), 1);
            chk({tag, "_hold_bit"}, int'(out_bit), ebit);
            chk({tag, "_hold_rdy"}, int'(in_ready), 0);
        end
        @(negedge clk);
        prog_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, int'(in_ready), 1);
        chk({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        logic [NUM_IN-1:0] vec;
        logic [NUM_IN-1:0] sym_vecs [4];
        int gb, gl, pop;
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        #23;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_bit",   int'(out_bit), 0);
        chk("rst_out_err",   int'(out_err), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;

        // 9symml: fixed vectors then random ones, against the symmetric function itself.
        build_9symml();
        load_prog(271);
        sym_vecs[0] = 9'b000000111; sym_vecs[1] = 9'b000111111;
        sym_vecs[2] = 9'b000000011; sym_vecs[3] = 9'b001111111;
        for (int t = 0; t < 8; t++) begin
            vec = (t < 4) ? sym_vecs[t] : NUM_IN'($urandom_range(0, 511));
            run_job("sym", vec, 0, gb, gl);
            pop = $countones(vec);
            chk("sym_func", gb, ((pop >= 3) && (pop <= 6)) ? 1 : 0);
            chk("sym_541", gl, 541);
        end

        // Reset during EVAL of gate 100, then rerun on the retained program.
        vec = 9'b101010101;
        accept("rst", vec);
        repeat (201) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        @(negedge clk); rst_n = 1'b1;
        run_job("rerun", vec, 0, gb, gl);
        chk("rerun_func", gb, 1);

        // Two-gate program: NOR2 0,1 -> 9 ; OUT 9.
        m_op[0] = 0; m_a[0] = 0; m_b[0] = 1; m_d[0] = 9;
        m_op[1] = 2; m_a[1] = 9; m_b[1] = 0; m_d[1] = 0;
        load_prog(2);
        for (int t = 0; t < 3; t++) begin
            vec = NUM_IN'($urandom_range(0, 127)) << 2;
            vec[0] = (t != 0); vec[1] = (t == 2);
            run_job("nor", vec, 0, gb, gl);
            chk("nor_val", gb, (t == 0) ? 1 : 0);
            chk("nor_lat", gl, 3);
        end

        // Backpressure in DONE with ignored program writes, then the same job again.
        vec = 9'b000000000;
        run_job("bp", vec, 10, gb, gl);
        run_job("bp_after", vec, 0, gb, gl);
        chk("bp_prog_kept", gb, 1);

        // prog_we and in_valid together: write wins, job starts next cycle on the new op.
        @(negedge clk);
        vec = 9'b000000010;
        prog_we = 1'b1; prog_addr = '0; prog_wdata = mk(2, 1, 0, 0);
        in_vec = vec; in_valid = 1'b1;
        #1;
        chk("coll_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        prog_we = 1'b0; in_valid = 1'b0;
        m_op[0] = 2; m_a[0] = 1;
        run_job("coll", vec, 0, gb, gl);
        chk("coll_new_op", gb, 1);
        chk("coll_lat", gl, 1);

        // Illegal ops at pc 0: reserved opcode, d==a, out-of-range operand.
        m_op[0] = 3; m_a[0] = 0; m_b[0] = 1; m_d[0] = 9;
        load_prog(1);
        run_job("e_rsvd", 9'h1ff, 0, gb, gl);
        chk("e_rsvd_lat", gl, 1);
        m_op[0] = 0; m_a[0] = 5; m_b[0] = 1; m_d[0] = 5;
        load_prog(1);
        run_job("e_alias", 9'h1ff, 0, gb, gl);
        chk("e_alias_err", int'(out_err), 1);
        m_op[0] = 2; m_a[0] = 300; m_b[0] = 0; m_d[0] = 0;
        load_prog(1);
        run_job("e_range", 9'h1ff, 0, gb, gl);
        chk("e_range_bit", gb, 0);

        // Random programs against the interpreter.
        for (int t = 0; t < 25; t++) begin
            int len;
            len = int'($urandom_range(1, 12));
            gen_rand(len);
            load_prog(len + 1);
            run_job("rnd", NUM_IN'($urandom_range(0, 511)), 0, gb, gl);
        end

        // A gate in the last slot must abort rather than wrap pc.
        for (int p = 0; p < PROG_DEPTH; p++) begin
            m_op[p] = 1; m_a[p] = 0; m_b[p] = 0; m_d[p] = 10;
        end
        load_prog(PROG_DEPTH);
        run_job("wrap", 9'h0a5, 0, gb, gl);
        chk("wrap_lat", gl, 2 * (PROG_DEPTH - 1) + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
